addsub_result_checker: RTL and testbench
========================================

Name: addsub_result_checker

Overview:
- Sequential consumer at the result end of the 16-bit add/subtract unit (sum, dif, of_sum, of_dif, lessthan).
- Accepts one operand/result tuple per handshake and recomputes the expected values in a 2-stage pipeline.
- Counts passes and failures, records a sticky per-field error mask, and can halt on the first error.
- Used as an in-system self-check next to the adder/subtractor and as the bench-side checker.

Parameters:
- WIDTH, 16, operand/result width (two's complement).
- CNT_W, 16, width of pass/fail counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: clear counters and mask, enter RUN.
- stop  in  1  pulse: leave RUN/HALT, go IDLE.
- halt_on_err  in  1  if 1, go to HALT on the first mismatch.
- in_valid  in  1  tuple valid.
- in_ready  out  1  checker can accept a tuple.
- A, B  in  WIDTH  operands (signed).
- sum, dif  in  WIDTH  DUT results.
- of_sum, of_dif, lessthan  in  1  DUT flags.
- busy  out  1  state is RUN.
- halted  out  1  state is HALT.
- pass_cnt, fail_cnt  out  CNT_W  saturating counters.
- err_mask  out  5  sticky OR of mismatching fields.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; both pipeline valid bits 0.
- States and transitions:
  - IDLE -start-> RUN.
  - RUN -stop-> IDLE.
  - RUN -(mismatch in stage 2 and halt_on_err)-> HALT.
  - HALT -start-> RUN.
  - HALT -stop-> IDLE.
  - start and stop in the same cycle: start wins.
- in_ready = (state==RUN). Transfer = in_valid & in_ready. in_valid while not ready is ignored; no tuple is buffered.
- Stage 1: register the tuple on a transfer; s1_valid is set.
- Stage 2 (compare), one cycle after stage 1, computes expected values, all modulo 2^WIDTH:
  - exp_sum = A+B; exp_dif = A-B.
  - exp_of_sum = (A[msb]==B[msb]) & (exp_sum[msb]!=A[msb]).
  - exp_of_dif = (A[msb]!=B[msb]) & (exp_dif[msb]!=A[msb]).
  - exp_lt = signed(A) < signed(B).
- Mismatch mask bit order: [0] sum, [1] dif, [2] of_sum, [3] of_dif, [4] lessthan.
- Commit at the end of stage 2: all-zero mask increments pass_cnt, otherwise fail_cnt; err_mask |= mask.
- Latency: a tuple transferred at edge N is counted at edge N+2.
- Counters saturate at 2^CNT_W-1 and never wrap.
- start (from any state): counters, err_mask and both valid bits are cleared at that edge; in-flight tuples are dropped. A transfer in the same cycle as start is dropped.
- stop: in-flight tuples still drain and are counted; no new transfers occur.
- HALT entry: the failing tuple is counted; a tuple already in stage 1 is discarded, not counted; in_ready drops the next cycle.
- Back-to-back transfers run at full throughput (1 tuple/cycle).

Optional Feature:
- Macro ADDSUB_CHK_FIRST_FAIL_EN.
- Defined: adds outputs first_fail_valid (1), first_fail_A (WIDTH), first_fail_B (WIDTH), first_fail_mask (5).
  - Captured at the first failing commit after start or reset.
  - Held until the next start or reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package addsub_chk_pkg holds:
  - WIDTH default and mask bit index constants (MSK_SUM..MSK_LT).
  - State enum typedef {IDLE, RUN, HALT}.
  - Packed struct typedef for the tuple (A, B, sum, dif, of_sum, of_dif, lessthan).
- One sub-module: addsub_ref_model, purely combinational. Input is the operand pair; outputs are the expected sum, dif, of_sum, of_dif and lessthan. It is instantiated in stage 2.

Test Plan:
- Correct DUT, tuples (0,0), (32767,-64), (-128,16384), (16,4), (-32768,-1) -> pass_cnt=5, fail_cnt=0, err_mask=0; the fifth tuple gives exp_of_dif=0 and dif=-32767.
- Tuple A=32767, B=1, sum=-32768, of_sum=0 (wrong) -> fail_cnt=1, err_mask=5'b00100 at edge N+2.
- halt_on_err=1; stream (16,4) good, then (256,-32) with bad dif, then (8192,32767) good -> pass_cnt=1, fail_cnt=1, halted=1, in_ready=0; third tuple not counted.
- Counters at CNT_W=4; 20 good tuples -> pass_cnt stays 15.
- Three tuples in flight, then stop -> all 3 counted, then busy=0. Repeat with start instead -> counters read 0.
- reset asserted mid-stream, async between edges -> all outputs 0 immediately; after release, in_ready=0 until start.

Source files
------------

// File: rtl/addsub_chk_pkg.sv
// ============================================================================
// Module   : addsub_chk_pkg
// Purpose  : Shared types and constants for the add/sub result checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package addsub_chk_pkg;

    localparam int DEF_WIDTH = 16;

    // Bit positions inside the per-tuple mismatch mask
    localparam int MSK_SUM = 0;
    localparam int MSK_DIF = 1;
    localparam int MSK_OFS = 2;
    localparam int MSK_OFD = 3;
    localparam int MSK_LT  = 4;
    localparam int MSK_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] dif;
        logic                 of_sum;
        logic                 of_dif;
        logic                 lessthan;
    } chk_tuple_t;

endpackage

`default_nettype wire

// File: rtl/addsub_ref_model.sv
// ============================================================================
// Module   : addsub_ref_model
// Purpose  : Combinational golden add/sub: sum, difference, overflows, signed <.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addsub_ref_model #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_exp_sum,
    output logic [WIDTH-1:0] o_exp_dif,
    output logic             o_exp_of_sum,
    output logic             o_exp_of_dif,
    output logic             o_exp_lt
);

    always_comb begin
        o_exp_sum    = i_a + i_b;
        o_exp_dif    = i_a - i_b;
        // Overflow: operand signs agree (add) / differ (sub) and the result sign flips
        o_exp_of_sum = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (o_exp_sum[WIDTH-1] != i_a[WIDTH-1]);
        o_exp_of_dif = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (o_exp_dif[WIDTH-1] != i_a[WIDTH-1]);
        o_exp_lt     = $signed(i_a) < $signed(i_b);
    end

endmodule

`default_nettype wire

// File: rtl/addsub_result_checker.sv
// ============================================================================
// Module   : addsub_result_checker
// Purpose  : 2-stage checker of add/sub results with pass/fail counters, sticky
//            error mask and optional halt; ADDSUB_CHK_FIRST_FAIL_EN adds capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addsub_result_checker
    import addsub_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             halt_on_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] dif,
    input  logic             of_sum,
    input  logic             of_dif,
    input  logic             lessthan,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [MSK_W-1:0] err_mask
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
    ,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_A,
    output logic [WIDTH-1:0] first_fail_B,
    output logic [MSK_W-1:0] first_fail_mask
`endif
);

    chk_state_e       state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    chk_tuple_t       s1_q, s1_d;
    chk_tuple_t       s2_q, s2_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [MSK_W-1:0] mask_q, mask_d;

    logic [WIDTH-1:0] w_exp_sum, w_exp_dif;
    logic             w_exp_of_sum, w_exp_of_dif, w_exp_lt;
    logic [MSK_W-1:0] w_mism;
    logic             w_xfer, w_fail, w_halt_entry;

    addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_a          (s2_q.a),
        .i_b          (s2_q.b),
        .o_exp_sum    (w_exp_sum),
        .o_exp_dif    (w_exp_dif),
        .o_exp_of_sum (w_exp_of_sum),
        .o_exp_of_dif (w_exp_of_dif),
        .o_exp_lt     (w_exp_lt)
    );

    always_comb begin
        w_mism          = '0;
        w_mism[MSK_SUM] = (s2_q.sum      != w_exp_sum);
        w_mism[MSK_DIF] = (s2_q.dif      != w_exp_dif);
        w_mism[MSK_OFS] = (s2_q.of_sum   != w_exp_of_sum);
        w_mism[MSK_OFD] = (s2_q.of_dif   != w_exp_of_dif);
        w_mism[MSK_LT]  = (s2_q.lessthan != w_exp_lt);
        w_fail          = s2_valid_q & (|w_mism);
        // A transfer coinciding with start belongs to the old session and is dropped
        w_xfer          = in_valid & in_ready & ~start;
        w_halt_entry    = (state_q == RUN) & ~start & ~stop & halt_on_err & w_fail;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start has priority over stop, stop over halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (start)             state_d = RUN;
                else if (stop)         state_d = IDLE;
                else if (w_halt_entry) state_d = HALT;
            end
            HALT: begin
                if (start)     state_d = RUN;
                else if (stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy     = (state_q == RUN);
        halted   = (state_q == HALT);
        in_ready = (state_q == RUN);
    end

    // Pipeline and commit
    always_comb begin
        s1_d       = w_xfer ? chk_tuple_t'{a: A, b: B, sum: sum, dif: dif,
                                           of_sum: of_sum, of_dif: of_dif,
                                           lessthan: lessthan} : s1_q;
        s1_valid_d = w_xfer & ~w_halt_entry;
        s2_d       = s1_q;
        s2_valid_d = s1_valid_q & ~w_halt_entry & ~start;

        pass_d = pass_q;
        fail_d = fail_q;
        mask_d = mask_q;
        if (start) begin
            pass_d = '0;
            fail_d = '0;
            mask_d = '0;
        end else if (s2_valid_q) begin
            if (w_fail) begin
                if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + 1'b1;
            end else begin
                if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + 1'b1;
            end
            mask_d = mask_q | w_mism;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            mask_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            mask_q     <= mask_d;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err_mask = mask_q;

`ifdef ADDSUB_CHK_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_b_q, ff_b_d;
    logic [MSK_W-1:0] ff_mask_q, ff_mask_d;

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_mask_d  = ff_mask_q;
        if (start) begin
            ff_valid_d = 1'b0;
            ff_a_d     = '0;
            ff_b_d     = '0;
            ff_mask_d  = '0;
        end else if (w_fail & ~ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_a_d     = s2_q.a;
            ff_b_d     = s2_q.b;
            ff_mask_d  = w_mism;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_mask_q  <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_mask_q  <= ff_mask_d;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_A     = ff_a_q;
    assign first_fail_B     = ff_b_q;
    assign first_fail_mask  = ff_mask_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_addsub_result_checker.sv
// ============================================================================
// Module   : tb_addsub_result_checker
// Purpose  : Self-checking bench; DUT pair with 16-bit and 4-bit counters,
//            compared each cycle against a queue-based behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

`define CHK(NAME, OBS, EXP) \
    begin \
        checks++; \
        assert ((OBS) === (EXP)) else begin \
            failures++; \
            $error("FAIL %s %s: observed=%0h expected=%0h", cur_tag, NAME, OBS, EXP); \
        end \
    end

module tb_addsub_result_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, stop = 1'b0, halt_on_err = 1'b0, in_valid = 1'b0;
    logic [15:0] A = '0, B = '0, sum = '0, dif = '0;
    logic        of_sum = 1'b0, of_dif = 1'b0, lessthan = 1'b0;

    logic        in_ready, busy, halted;
    logic [15:0] pass_cnt, fail_cnt;
    logic [4:0]  err_mask;
    logic        in_ready_s, busy_s, halted_s;
    logic [3:0]  pass_cnt_s, fail_cnt_s;
    logic [4:0]  err_mask_s;
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
    logic        ffv, ffv_s;
    logic [15:0] ffa, ffb, ffa_s, ffb_s;
    logic [4:0]  ffm, ffm_s;
`endif

    always #5 clk = ~clk;

    addsub_result_checker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .halt_on_err(halt_on_err),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .sum(sum), .dif(dif),
        .of_sum(of_sum), .of_dif(of_dif), .lessthan(lessthan), .busy(busy), .halted(halted),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_mask(err_mask)
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv), .first_fail_A(ffa), .first_fail_B(ffb), .first_fail_mask(ffm)
`endif
    );

    addsub_result_checker #(.WIDTH(16), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .halt_on_err(halt_on_err),
        .in_valid(in_valid), .in_ready(in_ready_s), .A(A), .B(B), .sum(sum), .dif(dif),
        .of_sum(of_sum), .of_dif(of_dif), .lessthan(lessthan), .busy(busy_s), .halted(halted_s),
        .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s), .err_mask(err_mask_s)
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv_s), .first_fail_A(ffa_s), .first_fail_B(ffb_s), .first_fail_mask(ffm_s)
`endif
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] a, b, sum, dif;
        logic        ofs, ofd, lt;
        int          age;   // edges since transfer
    } item_t;
    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_e;

    item_t       q[$];
    mstate_e     m_state = M_IDLE;
    int          m_pass = 0, m_fail = 0;
    logic [4:0]  m_mask = '0;
    bit          m_ffv = 0;
    logic [15:0] m_ffa = '0, m_ffb = '0;
    logic [4:0]  m_ffm = '0;
    int          checks = 0, failures = 0;
    string       cur_tag = "init";

    function automatic void ref_calc(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] es, output logic [15:0] ed,
                                     output logic eos, output logic eod, output logic elt);
        int ia, ib, s, d;
        ia  = $signed(a);
        ib  = $signed(b);
        s   = ia + ib;
        d   = ia - ib;
        es  = 16'(s);
        ed  = 16'(d);
        eos = (s > 32767) || (s < -32768);
        eod = (d > 32767) || (d < -32768);
        elt = (ia < ib);
    endfunction

    function automatic logic [4:0] exp_mask(input item_t t);
        logic [15:0] es, ed;
        logic        eos, eod, elt;
        logic [4:0]  m;
        ref_calc(t.a, t.b, es, ed, eos, eod, elt);
        m[0] = (t.sum !== es);
        m[1] = (t.dif !== ed);
        m[2] = (t.ofs !== eos);
        m[3] = (t.ofd !== eod);
        m[4] = (t.lt  !== elt);
        return m;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_pass = 0; m_fail = 0; m_mask = '0;
        m_ffv = 0; m_ffa = '0; m_ffb = '0; m_ffm = '0;
    endtask

    // Apply the effect of the coming rising edge using the current inputs
    task automatic model_edge();
        item_t nq[$];
        item_t t;
        bit    halt_now;
        logic [4:0] mk;
        halt_now = 0;
        if (reset) begin model_clear(); m_state = M_IDLE; return; end
        if (start) begin model_clear(); m_state = M_RUN;  return; end
        foreach (q[i]) begin
            if (q[i].age == 1) begin
                mk = exp_mask(q[i]);
                if (mk == 0) m_pass++; else m_fail++;
                m_mask |= mk;
                if (mk != 0 && !m_ffv) begin
                    m_ffv = 1; m_ffa = q[i].a; m_ffb = q[i].b; m_ffm = mk;
                end
                if (mk != 0 && halt_on_err && m_state == M_RUN && !stop) halt_now = 1;
            end
        end
        if (!halt_now) begin
            foreach (q[i]) if (q[i].age == 0) begin t = q[i]; t.age = 1; nq.push_back(t); end
            if (in_valid && m_state == M_RUN) begin
                t.a = A; t.b = B; t.sum = sum; t.dif = dif;
                t.ofs = of_sum; t.ofd = of_dif; t.lt = lessthan; t.age = 0;
                nq.push_back(t);
            end
        end
        q = nq;
        if (stop)          m_state = M_IDLE;
        else if (halt_now) m_state = M_HALT;
    endtask

    task automatic check_all();
        logic e_run, e_halt;
        e_run  = (m_state == M_RUN);
        e_halt = (m_state == M_HALT);
        `CHK("busy",       busy,       e_run)
        `CHK("halted",     halted,     e_halt)
        `CHK("in_ready",   in_ready,   e_run)
        `CHK("pass_cnt",   pass_cnt,   16'(sat(m_pass, 65535)))
        `CHK("fail_cnt",   fail_cnt,   16'(sat(m_fail, 65535)))
        `CHK("err_mask",   err_mask,   m_mask)
        `CHK("busy_s",     busy_s,     e_run)
        `CHK("halted_s",   halted_s,   e_halt)
        `CHK("in_ready_s", in_ready_s, e_run)
        `CHK("pass_cnt_s", pass_cnt_s, 4'(sat(m_pass, 15)))
        `CHK("fail_cnt_s", fail_cnt_s, 4'(sat(m_fail, 15)))
        `CHK("err_mask_s", err_mask_s, m_mask)
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
        `CHK("ff_valid",   ffv,   m_ffv)
        `CHK("ff_A",       ffa,   m_ffa)
        `CHK("ff_B",       ffb,   m_ffb)
        `CHK("ff_mask",    ffm,   m_ffm)
        `CHK("ff_valid_s", ffv_s, m_ffv)
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // corrupt: -1 none, 0..4 flips the field with that mask index
    task automatic set_tuple(input int a, input int b, input int corrupt);
        logic [15:0] es, ed;
        logic        eos, eod, elt;
        A = 16'(a);
        B = 16'(b);
        ref_calc(A, B, es, ed, eos, eod, elt);
        sum = es; dif = ed; of_sum = eos; of_dif = eod; lessthan = elt;
        case (corrupt)
            0: sum      = es ^ (16'h1 << $urandom_range(0, 15));
            1: dif      = ed ^ 16'h0001;
            2: of_sum   = ~eos;
            3: of_dif   = ~eod;
            4: lessthan = ~elt;
            default: ;
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        int ta[5];
        int tb[5];
        ta = '{0, 32767, -128, 16, -32768};
        tb = '{0, -64, 16384, 4, -1};

        cur_tag = "reset";
        #3;
        check_all();
        tick(); tick();
        #2 reset = 1'b0;

        // Five correct tuples back to back
        cur_tag = "good5";
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            set_tuple(ta[i], tb[i], -1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        `CHK("pass5", pass_cnt, 16'd5)
        `CHK("fail0", fail_cnt, 16'd0)
        `CHK("mask0", err_mask, 5'd0)

        // Wrong of_sum on a positive overflow; counted exactly two edges later
        cur_tag = "bad_ofs";
        pulse_start();
        set_tuple(32767, 1, 2);
        `CHK("ofs_stim", of_sum, 1'b0)
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        `CHK("fail_n1", fail_cnt, 16'd0)
        tick();
        `CHK("fail_n2", fail_cnt, 16'd1)
        `CHK("mask_n2", err_mask, 5'b00100)

        // Halt on first error; third tuple is discarded
        cur_tag = "halt";
        halt_on_err = 1'b1;
        pulse_start();
        in_valid = 1'b1;
        set_tuple(16, 4, -1);       tick();
        set_tuple(256, -32, 1);     tick();
        set_tuple(8192, 32767, -1); tick();
        in_valid = 1'b0;
        tick(); tick();
        `CHK("h_pass",   pass_cnt, 16'd1)
        `CHK("h_fail",   fail_cnt, 16'd1)
        `CHK("h_halted", halted,   1'b1)
        `CHK("h_ready",  in_ready, 1'b0)
        halt_on_err = 1'b0;

        // Saturation of the 4-bit counters
        cur_tag = "sat";
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_tuple(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), -1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        `CHK("sat_s",  pass_cnt_s, 4'd15)
        `CHK("sat_16", pass_cnt,   16'd20)

        // Stop with tuples in flight: all drain and are counted
        cur_tag = "stop_drain";
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin set_tuple(i * 1000, -i, -1); tick(); end
        in_valid = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();
        `CHK("stop_pass", pass_cnt, 16'd3)
        `CHK("stop_busy", busy,     1'b0)

        // Start with tuples in flight: everything dropped
        cur_tag = "start_drop";
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin set_tuple(i, i + 7, -1); tick(); end
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b0;
        tick(); tick();
        `CHK("drop_pass", pass_cnt, 16'd0)

        // start and stop together: start wins
        cur_tag = "start_stop";
        stop = 1'b1; start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        `CHK("ss_busy", busy, 1'b1)

        // Randomized traffic with corruption and control pulses
        cur_tag = "random";
        for (int i = 0; i < 300; i++) begin
            set_tuple(($urandom_range(0, 7) == 0) ? 32767 : int'($urandom_range(0, 65535)),
                      ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1);
            in_valid    = ($urandom_range(0, 3) != 0);
            halt_on_err = ($urandom_range(0, 3) == 0);
            start       = ($urandom_range(0, 24) == 0);
            stop        = ($urandom_range(0, 29) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; halt_on_err = 1'b0;

        // Asynchronous reset between edges while streaming
        cur_tag = "async_reset";
        pulse_start();
        in_valid = 1'b1;
        set_tuple(5, 9, 3); tick();
        set_tuple(7, 1, -1); tick();
        #2 reset = 1'b1;
        #1;
        model_clear();
        m_state = M_IDLE;
        check_all();
        `CHK("ar_pass", pass_cnt, 16'd0)
        `CHK("ar_busy", busy,     1'b0)
        @(negedge clk);
        reset = 1'b0;
        tick(); tick();
        `CHK("ar_ready", in_ready, 1'b0)
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
